fifo_rd_ctrl: RTL and testbench

Read-side controller for the async FIFO. It sits in the read clock domain opposite the write-side memory port. It generates the binary read address into the FIFO memory and the Gray-coded read pointer that is synchronized back to the write domain. It also derives the registered empty flag and occupancy level, and presents popped words on a registered valid/ready output stage.

---
 rtl/fifo_rd_ctrl_if.sv | 21 ++
 rtl/fifo_rd_ctrl.sv | 77 +++++++
 tb/tb_fifo_rd_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side output stream of the async FIFO: registered data/valid from the
// controller, ready back from the consumer.
interface fifo_rd_ctrl_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;

  modport master (
    output rd_data,
    output rd_valid,
    input  rd_ready
  );

  modport slave (
    input  rd_data,
    input  rd_valid,
    output rd_ready
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO. Keeps the binary read pointer,
// publishes its Gray form for the write domain, derives a registered empty
// flag and occupancy, and pops memory words into a registered valid/ready
// output stage that can stream one word per cycle.
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  input  logic [DATA_WIDTH-1:0] rdata_mem,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic                  rempty,
  output logic [ADDR_WIDTH:0]   rd_level,
  fifo_rd_ctrl_if.master        rd_if
);

  localparam int FIFO_DEPTH = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH:0] rbin;
  logic [ADDR_WIDTH:0] rbinnext;
  logic [ADDR_WIDTH:0] rgraynext;
  logic [ADDR_WIDTH:0] wbin_s;
  logic [ADDR_WIDTH:0] level_next;
  logic                pop;

  // Pop only from the registered empty flag, and only when the output
  // register is free or being drained this cycle.
  assign pop = !rempty && (!rd_if.rd_valid || rd_if.rd_ready);

  assign raddr = rbin[ADDR_WIDTH-1:0];

  // Next binary/Gray read pointer and synchronized write pointer in binary.
  always_comb begin
    rbinnext  = rbin + {{ADDR_WIDTH{1'b0}}, pop};
    rgraynext = (rbinnext >> 1) ^ rbinnext;
    wbin_s    = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) begin
      wbin_s[i] = ^(rq2_wptr >> i);
    end
    level_next = wbin_s - rbinnext;
  end

  // Pointer, flag, level and output-stage registers; reset overrides all.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin           <= '0;
      rptr           <= '0;
      rempty         <= 1'b1;
      rd_level       <= '0;
      rd_if.rd_data  <= '0;
      rd_if.rd_valid <= 1'b0;
    end else begin
      rbin     <= rbinnext;
      rptr     <= rgraynext;
      rempty   <= (rgraynext == rq2_wptr);
      rd_level <= level_next;
      if (pop) begin
        rd_if.rd_data  <= rdata_mem;
        rd_if.rd_valid <= 1'b1;
      end else if (rd_if.rd_ready) begin
        rd_if.rd_valid <= 1'b0;
      end
    end
  end

  // The level can never legally exceed the memory depth.
  always_ff @(posedge rclk) begin
    if (rrst_n) begin
      assert ({1'b0, rd_level} <= (ADDR_WIDTH+2)'(FIFO_DEPTH))
        else $error("rd_level out of range");
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: models the write side (memory plus
// Gray write pointer) and scores popped words against a queue.
module tb_fifo_rd_ctrl;

  logic       rclk;
  logic       rrst_n;
  logic [4:0] rq2_wptr;
  logic [7:0] rdata_mem;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       rempty;
  logic [4:0] rd_level;

  logic [7:0] mem [16];
  logic [7:0] exp_q [$];
  logic [4:0] wbin;
  logic [7:0] exp_word;
  int         pass_cnt;
  int         total_cnt;

  fifo_rd_ctrl_if #(.DATA_WIDTH(8)) rd_if ();

  fifo_rd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rq2_wptr  (rq2_wptr),
    .rdata_mem (rdata_mem),
    .raddr     (raddr),
    .rptr      (rptr),
    .rempty    (rempty),
    .rd_level  (rd_level),
    .rd_if     (rd_if.master)
  );

  assign rdata_mem = mem[raddr];

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] d);
    mem[wbin[3:0]] = d;
    exp_q.push_back(d);
    wbin = wbin + 5'd1;
    rq2_wptr = gray(wbin);
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    rd_if.rd_ready = 1'b0;
    wbin = '0;
    rq2_wptr = '0;
    exp_q.delete();
    tick();
    tick();
    rrst_n = 1'b1;
  endtask

  task automatic test_reset();
    rrst_n = 1'b0;
    rd_if.rd_ready = 1'b0;
    rq2_wptr = 5'b00011;
    tick();
    tick();
    total_cnt++; if (rempty !== 1'b1) $display("[TB] FAIL reset_rempty: got %b expected 1", rempty); else pass_cnt++;
    total_cnt++; if (rptr !== 5'b0) $display("[TB] FAIL reset_rptr: got %b expected 00000", rptr); else pass_cnt++;
    total_cnt++; if (raddr !== 4'h0) $display("[TB] FAIL reset_raddr: got %h expected 0", raddr); else pass_cnt++;
    total_cnt++; if (rd_if.rd_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", rd_if.rd_valid); else pass_cnt++;
    total_cnt++; if (rd_level !== 5'd0) $display("[TB] FAIL reset_level: got %0d expected 0", rd_level); else pass_cnt++;
    rrst_n = 1'b1;
    tick();
    total_cnt++; if (rempty !== 1'b0) $display("[TB] FAIL release_rempty: got %b expected 0", rempty); else pass_cnt++;
    total_cnt++; if (rd_level !== 5'd2) $display("[TB] FAIL release_level: got %0d expected 2", rd_level); else pass_cnt++;
    total_cnt++; if (rd_if.rd_valid !== 1'b0) $display("[TB] FAIL release_valid: got %b expected 0", rd_if.rd_valid); else pass_cnt++;
  endtask

  task automatic test_single_word();
    do_reset();
    rd_if.rd_ready = 1'b1;
    write_word(8'hA5);
    tick();
    total_cnt++; if (rempty !== 1'b0) $display("[TB] FAIL single_rempty_fall: got %b expected 0", rempty); else pass_cnt++;
    total_cnt++; if (rd_if.rd_valid !== 1'b0) $display("[TB] FAIL single_valid_early: got %b expected 0", rd_if.rd_valid); else pass_cnt++;
    total_cnt++; if (rd_level !== 5'd1) $display("[TB] FAIL single_level: got %0d expected 1", rd_level); else pass_cnt++;
    tick();
    total_cnt++; if (rd_if.rd_valid !== 1'b1) $display("[TB] FAIL single_valid: got %b expected 1", rd_if.rd_valid); else pass_cnt++;
    if (rd_if.rd_valid && rd_if.rd_ready && exp_q.size() > 0) begin
      exp_word = exp_q.pop_front();
      total_cnt++; if (rd_if.rd_data !== exp_word) $display("[TB] FAIL single_data: got %h expected %h", rd_if.rd_data, exp_word); else pass_cnt++;
    end
    total_cnt++; if (rempty !== 1'b1) $display("[TB] FAIL single_rempty_rise: got %b expected 1", rempty); else pass_cnt++;
    total_cnt++; if (rptr !== 5'b00001) $display("[TB] FAIL single_rptr: got %b expected 00001", rptr); else pass_cnt++;
    total_cnt++; if (raddr !== 4'h1) $display("[TB] FAIL single_raddr: got %h expected 1", raddr); else pass_cnt++;
    total_cnt++; if (rd_level !== 5'd0) $display("[TB] FAIL single_level_after: got %0d expected 0", rd_level); else pass_cnt++;
    tick();
    total_cnt++; if (rd_if.rd_valid !== 1'b0) $display("[TB] FAIL single_valid_drop: got %b expected 0", rd_if.rd_valid); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    write_word(8'h11);
    write_word(8'h22);
    write_word(8'h33);
    tick();
    total_cnt++; if (rd_level !== 5'd3) $display("[TB] FAIL bp_level: got %0d expected 3", rd_level); else pass_cnt++;
    tick();
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if (rd_if.rd_valid !== 1'b1) $display("[TB] FAIL bp_stall_valid: got %b expected 1", rd_if.rd_valid); else pass_cnt++;
      total_cnt++; if (rd_if.rd_data !== exp_q[0]) $display("[TB] FAIL bp_stall_data: got %h expected %h", rd_if.rd_data, exp_q[0]); else pass_cnt++;
      total_cnt++; if (raddr !== 4'h1) $display("[TB] FAIL bp_stall_raddr: got %h expected 1", raddr); else pass_cnt++;
      tick();
    end
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (rd_if.rd_valid !== 1'b1) $display("[TB] FAIL bp_stream_valid: got %b expected 1 at beat %0d", rd_if.rd_valid, i); else pass_cnt++;
      if (exp_q.size() > 0) begin
        exp_word = exp_q.pop_front();
        total_cnt++; if (rd_if.rd_data !== exp_word) $display("[TB] FAIL bp_stream_data: got %h expected %h", rd_if.rd_data, exp_word); else pass_cnt++;
      end
      tick();
    end
    total_cnt++; if (rd_if.rd_valid !== 1'b0) $display("[TB] FAIL bp_end_valid: got %b expected 0", rd_if.rd_valid); else pass_cnt++;
    total_cnt++; if (rempty !== 1'b1) $display("[TB] FAIL bp_end_rempty: got %b expected 1", rempty); else pass_cnt++;
  endtask

  task automatic test_full();
    int got;
    do_reset();
    for (int i = 0; i < 16; i++) write_word(8'(8'h80 + i));
    tick();
    total_cnt++; if (rempty !== 1'b0) $display("[TB] FAIL full_rempty: got %b expected 0", rempty); else pass_cnt++;
    total_cnt++; if (rd_level !== 5'd16) $display("[TB] FAIL full_level: got %0d expected 16", rd_level); else pass_cnt++;
    rd_if.rd_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
      tick();
      if (rd_if.rd_valid) begin
        got++;
        total_cnt++; if (rempty !== (got == 16)) $display("[TB] FAIL full_drain_rempty: got %b after pop %0d", rempty, got); else pass_cnt++;
        if (exp_q.size() > 0) begin
          exp_word = exp_q.pop_front();
          total_cnt++; if (rd_if.rd_data !== exp_word) $display("[TB] FAIL full_data: got %h expected %h", rd_if.rd_data, exp_word); else pass_cnt++;
        end
      end
    end
    total_cnt++; if (got !== 16) $display("[TB] FAIL full_pop_count: got %0d expected 16", got); else pass_cnt++;
    total_cnt++; if (rptr !== 5'b11000) $display("[TB] FAIL full_rptr: got %b expected 11000", rptr); else pass_cnt++;
    total_cnt++; if (rd_level !== 5'd0) $display("[TB] FAIL full_level_end: got %0d expected 0", rd_level); else pass_cnt++;
  endtask

  task automatic test_wrap();
    int written;
    int transfers;
    logic [4:0] prev_rptr;
    logic [4:0] k;
    do_reset();
    rd_if.rd_ready = 1'b1;
    written = 0;
    transfers = 0;
    prev_rptr = '0;
    for (int cyc = 0; cyc < 300 && transfers < 40; cyc++) begin
      while (written < 40 && (written - transfers) < 16) begin
        write_word(8'(written * 3 + 1));
        written++;
      end
      tick();
      if (rd_if.rd_valid) begin
        k = 5'(transfers + 1);
        total_cnt++; if (raddr !== k[3:0]) $display("[TB] FAIL wrap_raddr: got %h expected %h", raddr, k[3:0]); else pass_cnt++;
        total_cnt++; if (rptr !== gray(k)) $display("[TB] FAIL wrap_rptr: got %b expected %b", rptr, gray(k)); else pass_cnt++;
        total_cnt++; if ($countones(rptr ^ prev_rptr) !== 1) $display("[TB] FAIL wrap_gray_step: got %b from %b expected one bit change", rptr, prev_rptr); else pass_cnt++;
        if (exp_q.size() > 0) begin
          exp_word = exp_q.pop_front();
          total_cnt++; if (rd_if.rd_data !== exp_word) $display("[TB] FAIL wrap_data: got %h expected %h", rd_if.rd_data, exp_word); else pass_cnt++;
        end
        prev_rptr = rptr;
        transfers++;
      end
    end
    total_cnt++; if (transfers !== 40) $display("[TB] FAIL wrap_count: got %0d expected 40", transfers); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    write_word(8'h71);
    write_word(8'h72);
    write_word(8'h73);
    tick();
    tick();
    total_cnt++; if (rd_if.rd_valid !== 1'b1) $display("[TB] FAIL mid_pre_valid: got %b expected 1", rd_if.rd_valid); else pass_cnt++;
    rrst_n = 1'b0;
    tick();
    total_cnt++; if (rd_if.rd_valid !== 1'b0) $display("[TB] FAIL mid_valid: got %b expected 0", rd_if.rd_valid); else pass_cnt++;
    total_cnt++; if (raddr !== 4'h0) $display("[TB] FAIL mid_raddr: got %h expected 0", raddr); else pass_cnt++;
    total_cnt++; if (rempty !== 1'b1) $display("[TB] FAIL mid_rempty: got %b expected 1", rempty); else pass_cnt++;
    total_cnt++; if (rptr !== 5'b0) $display("[TB] FAIL mid_rptr: got %b expected 00000", rptr); else pass_cnt++;
    rrst_n = 1'b1;
    tick();
    total_cnt++; if (rd_if.rd_valid !== 1'b0) $display("[TB] FAIL mid_no_extra_pop: got %b expected 0", rd_if.rd_valid); else pass_cnt++;
    total_cnt++; if (rempty !== 1'b0) $display("[TB] FAIL mid_rempty_after: got %b expected 0", rempty); else pass_cnt++;
    rd_if.rd_ready = 1'b1;
    tick();
    total_cnt++; if (rd_if.rd_valid !== 1'b1) $display("[TB] FAIL mid_repop_valid: got %b expected 1", rd_if.rd_valid); else pass_cnt++;
    if (exp_q.size() > 0) begin
      exp_word = exp_q.pop_front();
      total_cnt++; if (rd_if.rd_data !== exp_word) $display("[TB] FAIL mid_repop_data: got %h expected %h", rd_if.rd_data, exp_word); else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    wbin = '0;
    rrst_n = 1'b0;
    rq2_wptr = '0;
    rd_if.rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_single_word();
    test_backpressure();
    test_full();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
